// File: rtl/prog_fetch_ctrl_if.sv
// rtl/prog_fetch_ctrl_if.sv - program-memory bus and instruction-bundle handshake for prog_fetch_ctrl
//
// Groups the byte-wide program memory port (Byte_Mem style, active-low chip
// select) with the instruction bundle handed to the decoder.
//   rom_cs        : memory chip select, active low
//   rom_addr      : memory byte address
//   rom_dout      : memory read data (registered by the memory on negedge)
//   instr_valid   : bundle valid
//   instr_ready   : decoder accepts bundle
//   instr_op      : opcode byte
//   instr_b1/b2   : operand bytes, 0 when absent
//   instr_len     : byte count 1..3
//   instr_pc      : address of the opcode
//   instr_illegal : opcode outside the supported table
// master = fetch sequencer side, slave = memory/decoder side.
interface prog_fetch_ctrl_if #(
  parameter int ADDRWIDTH = 8
);
  logic                 rom_cs;
  logic [ADDRWIDTH-1:0] rom_addr;
  logic [7:0]           rom_dout;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [7:0]           instr_op;
  logic [7:0]           instr_b1;
  logic [7:0]           instr_b2;
  logic [1:0]           instr_len;
  logic [ADDRWIDTH-1:0] instr_pc;
  logic                 instr_illegal;

  modport master (
    output rom_cs, rom_addr,
    input  rom_dout,
    output instr_valid,
    input  instr_ready,
    output instr_op, instr_b1, instr_b2, instr_len, instr_pc, instr_illegal
  );

  modport slave (
    input  rom_cs, rom_addr,
    output rom_dout,
    input  instr_valid,
    output instr_ready,
    input  instr_op, instr_b1, instr_b2, instr_len, instr_pc, instr_illegal
  );
endinterface

// File: rtl/prog_fetch_ctrl.sv
// rtl/prog_fetch_ctrl.sv - MCU51 instruction fetch sequencer for byte-wide program memory
//
// Owns the program counter, fetches opcode plus 0..2 operand bytes one byte
// per cycle, decodes instruction length for the MOV/NOP subset and presents
// the complete instruction over a valid/ready handshake.
//   clk       : system clock (memory samples on negedge, this block on posedge)
//   rst       : synchronous reset, active high
//   run       : 1 = new byte fetches may start
//   jmp_valid : redirect pulse; jmp_addr is the new fetch address
//   bus       : memory port + instruction bundle (prog_fetch_ctrl_if.master)
// All outputs are registered.
module prog_fetch_ctrl #(
  parameter int                   ADDRWIDTH = 8,
  parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 jmp_valid,
  input  logic [ADDRWIDTH-1:0] jmp_addr,
  prog_fetch_ctrl_if.master    bus
);

  typedef enum logic [2:0] {IDLE, F_OP, F_B1, F_B2, VALID} state_t;

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] pc_q, pc_d;
  logic                 cs_q, cs_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic [7:0]           op_q, op_d;
  logic [7:0]           b1_q, b1_d;
  logic [7:0]           b2_q, b2_d;
  logic [1:0]           len_q, len_d;
  logic [ADDRWIDTH-1:0] ipc_q, ipc_d;
  logic                 ill_q, ill_d;

  logic [1:0]           dec_len;
  logic                 dec_ill;
  logic                 fetching;

  // Returns {illegal, len}. Unsupported opcodes are treated as 1-byte so the
  // fetch stream keeps moving.
  function automatic logic [2:0] decode_len(input logic [7:0] op);
    logic [2:0] r;
    case (op) inside
      8'h00, [8'hE6:8'hEF], [8'hF6:8'hFF]:                   r = {1'b0, 2'd1};
      8'h74, [8'h76:8'h7F], 8'hE5, 8'hF5,
      [8'h86:8'h8F], [8'hA6:8'hAF]:                          r = {1'b0, 2'd2};
      8'h75, 8'h85:                                          r = {1'b0, 2'd3};
      default:                                               r = {1'b1, 2'd1};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    op_d    = op_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    len_d   = len_q;
    ipc_d   = ipc_q;
    ill_d   = ill_q;

    {dec_ill, dec_len} = decode_len(bus.rom_dout);
    // A byte is only taken when the read was actually issued this cycle
    // (cs low) and run is still high; otherwise the fetch state just waits.
    fetching = !cs_q && run;

    if (jmp_valid) begin
      pc_d    = jmp_addr;
      addr_d  = jmp_addr;
      valid_d = 1'b0;
      state_d = run ? F_OP : IDLE;
      cs_d    = !run;
    end else begin
      case (state_q)
        IDLE: begin
          cs_d = 1'b1;
          if (run) begin
            state_d = F_OP;
            cs_d    = 1'b0;
            addr_d  = pc_q;
          end
        end
        F_OP: begin
          if (fetching) begin
            op_d   = bus.rom_dout;
            b1_d   = 8'h00;
            b2_d   = 8'h00;
            len_d  = dec_len;
            ill_d  = dec_ill;
            ipc_d  = pc_q;
            pc_d   = pc_q + 1'b1;
            addr_d = pc_q + 1'b1;
            if (dec_len == 2'd1) begin
              state_d = VALID;
              valid_d = 1'b1;
              cs_d    = 1'b1;
            end else begin
              state_d = F_B1;
              cs_d    = 1'b0;
            end
          end else begin
            cs_d = !run;
          end
        end
        F_B1: begin
          if (fetching) begin
            b1_d   = bus.rom_dout;
            pc_d   = pc_q + 1'b1;
            addr_d = pc_q + 1'b1;
            if (len_q == 2'd2) begin
              state_d = VALID;
              valid_d = 1'b1;
              cs_d    = 1'b1;
            end else begin
              state_d = F_B2;
              cs_d    = 1'b0;
            end
          end else begin
            cs_d = !run;
          end
        end
        F_B2: begin
          if (fetching) begin
            b2_d    = bus.rom_dout;
            pc_d    = pc_q + 1'b1;
            addr_d  = pc_q + 1'b1;
            state_d = VALID;
            valid_d = 1'b1;
            cs_d    = 1'b1;
          end else begin
            cs_d = !run;
          end
        end
        VALID: begin
          cs_d = 1'b1;
          if (bus.instr_ready) begin
            valid_d = 1'b0;
            addr_d  = pc_q;
            state_d = run ? F_OP : IDLE;
            cs_d    = !run;
          end
        end
        default: begin
          state_d = IDLE;
          cs_d    = 1'b1;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cs_q    <= 1'b1;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      op_q    <= 8'h00;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      len_q   <= 2'd1;
      ipc_q   <= RESET_PC;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.rom_cs        = cs_q;
  assign bus.rom_addr      = addr_q;
  assign bus.instr_valid   = valid_q;
  assign bus.instr_op      = op_q;
  assign bus.instr_b1      = b1_q;
  assign bus.instr_b2      = b2_q;
  assign bus.instr_len     = len_q;
  assign bus.instr_pc      = ipc_q;
  assign bus.instr_illegal = ill_q;

endmodule

// File: doc/prog_fetch_ctrl.md
Name: prog_fetch_ctrl

Overview:
Instruction fetch sequencer for the MCU51 core's byte-wide program memory (Byte_Mem family: active-low CS, byte address, data registered on the falling clock edge). It owns the program counter and reads the opcode and 0–2 operand bytes, one byte per cycle. It decodes the instruction length for the supported MOV/NOP subset and presents a complete instruction to the decoder over a valid/ready handshake. A core-side redirect (jump) can restart fetching at any time.

Parameters:
ADDRWIDTH, 8, program address width; must match the memory's ADDRWIDTH.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock; memory samples on negedge, this block on posedge
rst  input  1  synchronous reset, active-high
run  input  1  1 = fetching allowed; 0 = no new byte fetch is started
jmp_valid  input  1  redirect request, single-cycle pulse
jmp_addr  input  ADDRWIDTH  redirect target
rom_cs  output  1  memory chip select, active low
rom_addr  output  ADDRWIDTH  memory byte address
rom_dout  input  8  memory read data
instr_valid  output  1  instruction bundle valid
instr_ready  input  1  decoder accepts bundle
instr_op  output  8  opcode byte
instr_b1  output  8  first operand byte (0 if absent)
instr_b2  output  8  second operand byte (0 if absent)
instr_len  output  2  byte count, 1..3
instr_pc  output  ADDRWIDTH  address of the opcode
instr_illegal  output  1  opcode is outside the supported table

Behaviour:
- Registered outputs only. Reset values: rom_cs=1, rom_addr=RESET_PC, instr_valid=0, instr_op/b1/b2=0, instr_len=1, instr_pc=RESET_PC, instr_illegal=0, pc=RESET_PC, state IDLE.
- Memory timing: an address driven during cycle k returns data at that cycle's negedge. This block captures rom_dout at the posedge that ends cycle k. Each byte costs 1 cycle and rom_cs=0 in that cycle.
- States: IDLE, F_OP, F_B1, F_B2, VALID.
- IDLE: rom_cs=1. If run=1, go to F_OP with rom_addr=pc.
- F_OP: capture the opcode, set instr_pc=pc, pc<=pc+1, rom_addr<=pc+1. Go to VALID if len=1, else F_B1. Clear b1/b2.
- F_B1: capture b1, pc<=pc+1. Go to VALID if len=2, else F_B2.
- F_B2: capture b2, pc<=pc+1. Go to VALID.
- F_OP/F_B1/F_B2 with run=0: rom_cs=1, no capture, state and pc held.
- VALID: instr_valid=1, rom_cs=1, bundle held stable until instr_valid&&instr_ready. On accept: instr_valid<=0, rom_addr<=pc, go to F_OP if run=1, else IDLE. Throughput is len+1 cycles per instruction at full readiness.
- Length table:
  - 1 byte: 00, E6–EF, F6–FF.
  - 2 bytes: 74, 76–7F, E5, F5, 86–8F, A6–AF.
  - 3 bytes: 75, 85.
  - Any other opcode: len=1, instr_illegal=1. Fetch continues.
- PC arithmetic is modulo 2^ADDRWIDTH. An instruction straddling FF→00 fetches its operands from 00, 01. instr_pc keeps the opcode address.
- Redirect: jmp_valid in any non-reset state sets pc<=jmp_addr, rom_addr<=jmp_addr, instr_valid<=0, discards the partial bundle, and goes to F_OP (IDLE if run=0). It takes priority over capture and over run. If it coincides with an accept, the accepted bundle counts as consumed and the redirect still applies.
- rst overrides everything, including mid-instruction. The next fetch starts from RESET_PC.
- instr_ready while instr_valid=0 is ignored.

Test Plan:
- Memory preloaded with 74 07 F8 7F 03 at 00; rst then run=1, ready=1 → bundles {op74,b1=07,len2,pc00}, {opF8,len1,pc02}, {op7F,b1=03,len2,pc03}. First instr_valid 3 cycles after rst deasserts. rom_cs low only in fetch cycles.
- 75 01 06 at 0C → {op75,b1=01,b2=06,len3,pc0C}. The next opcode fetch is at 0F.
- ready held 0 for 5 cycles on a bundle → bundle stable, rom_cs=1, no address advance. Accept → fetch resumes at the correct pc.
- jmp_valid (jmp_addr=15) during F_B1 of a 3-byte instruction → no bundle for it, next bundle pc=15 {op85,b1=20,b2=01,len3}. Also redirect coincident with accept → both honoured.
- 74 at FF, 55 at 00 → {op74,b1=55,pc=FF}. Next opcode fetched from 01.
- Opcode A5 → len1, instr_illegal=1. rst asserted mid-F_B2 → all outputs at reset values next cycle, refetch from RESET_PC.
